// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// input_debouncer : per-channel synchroniser + glitch-rejecting debouncer
//                   with registered rise/fall pulses.  Rev 1.0
// ============================================================================
module input_debouncer #(
   parameter int WIDTH       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_MAX     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] clean_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             busy
);

   localparam int            CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
   localparam logic [0:0]    S_IDLE   = 1'b0;
   localparam logic [0:0]    S_VERIFY = 1'b1;

   logic [WIDTH-1:0] verify_w;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_q;
         logic [0:0]             state_q, state_d;
         logic [CW-1:0]          cnt_q, cnt_d;
         logic                   clean_q, clean_d;
         logic                   rise_q, rise_d;
         logic                   fall_q, fall_d;
         logic                   sync_w;

         assign sync_w = sync_q[SYNC_STAGES-1];

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            clean_d = clean_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
               S_IDLE: begin
                  cnt_d = '0;
                  if (sync_w != clean_q) begin
                     state_d = S_VERIFY;
                     cnt_d   = CW'(1);
                  end
               end
               default: begin
                  if (sync_w == clean_q) begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                  end else if (cnt_q == CNT_LAST) begin
                     // Input held long enough: commit it and flag the edge.
                     clean_d = sync_w;
                     rise_d  = sync_w;
                     fall_d  = ~sync_w;
                     state_d = S_IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            endcase
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q  <= '0;
               state_q <= S_IDLE;
               cnt_q   <= '0;
               clean_q <= 1'b0;
               rise_q  <= 1'b0;
               fall_q  <= 1'b0;
            end else begin
               sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_in[i]};
               state_q <= state_d;
               cnt_q   <= cnt_d;
               clean_q <= clean_d;
               rise_q  <= rise_d;
               fall_q  <= fall_d;
            end
         end

         assign clean_out[i] = clean_q;
         assign rise[i]      = rise_q;
         assign fall[i]      = fall_q;
         assign verify_w[i]  = (state_q == S_VERIFY);
      end
   endgenerate

   assign busy = |verify_w;

endmodule
`default_nettype wire
